// File: rtl/dbg_trace_pkg.sv
// Shared types and encodings for the debug-bus trace buffer.
package dbg_trace_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StPost,
    StDone
  } state_e;

  // Entry kind, highest priority first: memwrite, memread, writeback, none.
  localparam logic [1:0] KindNone  = 2'd0;
  localparam logic [1:0] KindWb    = 2'd1;
  localparam logic [1:0] KindRead  = 2'd2;
  localparam logic [1:0] KindWrite = 2'd3;

  // Capture qualifier selected by the mode input.
  localparam logic [1:0] ModeAll = 2'd0;
  localparam logic [1:0] ModeWb  = 2'd1;
  localparam logic [1:0] ModeMem = 2'd2;
  localparam logic [1:0] ModeAny = 2'd3;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefCycW  = 16;

  // Entry layout at default widths; the RAM stores the same packing flattened.
  typedef struct packed {
    logic [DefCycW-1:0]  cycle;
    logic [1:0]          kind;
    logic [DefDataW-1:0] pc;
    logic [DefDataW-1:0] data;
  } entry_t;

  function automatic int unsigned entry_width(input int unsigned data_w,
                                              input int unsigned cyc_w);
    return cyc_w + 2 + 2 * data_w;
  endfunction

endpackage

// File: rtl/dbg_trace_ram.sv
// Trace storage: flop array with one write port and one asynchronous read port.
module dbg_trace_ram #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 82
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  // Contents are not reset; validity is tracked by the pointers in the top.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dbg_trace_buffer.sv
// Trace capture around a PC trigger with a valid/ready drain port.
module dbg_trace_buffer
  import dbg_trace_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CYC_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        dbg_pc,
  input  logic [DATA_W-1:0]        dbg_instr,
  input  logic [DATA_W-1:0]        dbg_alu,
  input  logic [DATA_W-1:0]        dbg_wb,
  input  logic [DATA_W-1:0]        dbg_mem_addr,
  input  logic                     dbg_memread,
  input  logic                     dbg_memwrite,
  input  logic                     dbg_wb_we,
  input  logic                     arm,
  input  logic [1:0]               mode,
  input  logic                     trig_en,
  input  logic [DATA_W-1:0]        trig_pc,
  input  logic [$clog2(DEPTH):0]   post_count,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_W-1:0]        rd_pc,
  output logic [DATA_W-1:0]        rd_data,
  output logic [CYC_W-1:0]         rd_cycle,
  output logic [1:0]               rd_kind,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = entry_width(DATA_W, CYC_W);
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  state_e            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d, rem_q, rem_d;
  logic              ovf_q, ovf_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;

  logic              qual, hit, wr_en, pop;
  logic [1:0]        kind;
  logic [DATA_W-1:0] data;
  logic [CW-1:0]     post_clamped;
  logic [EW-1:0]     rdata;

  // The instruction word is visible on the bus but is not part of an entry.
  logic unused_instr;
  assign unused_instr = ^dbg_instr;

  // Qualify the current cycle and pick entry kind/data by priority.
  always_comb begin
    qual = 1'b0;
    kind = KindNone;
    data = dbg_alu;
    unique case (mode)
      ModeAll: qual = 1'b1;
      ModeWb:  qual = dbg_wb_we;
      ModeMem: qual = dbg_memread | dbg_memwrite;
      ModeAny: qual = dbg_wb_we | dbg_memread | dbg_memwrite;
      default: qual = 1'b0;
    endcase
    if (dbg_memwrite) begin
      kind = KindWrite;
      data = dbg_mem_addr;
    end else if (dbg_memread) begin
      kind = KindRead;
      data = dbg_mem_addr;
    end else if (dbg_wb_we) begin
      kind = KindWb;
      data = dbg_wb;
    end
  end

  assign hit          = (dbg_pc == trig_pc);
  assign post_clamped = (post_count > DepthC) ? DepthC : post_count;
  assign wr_en        = !arm && qual && (state_q == StArmed || state_q == StPost);
  assign rd_valid     = (state_q == StDone) && (count_q != '0);
  assign pop          = !arm && rd_valid && rd_ready;

  // Next-state: arm restarts everything, otherwise capture or drain.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rem_d    = rem_q;
    ovf_d    = ovf_q;
    cyc_d    = cyc_q;
    if (arm) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      cyc_d    = '0;
      rem_d    = post_clamped;
      if (trig_en)                 state_d = StArmed;
      else if (post_count == '0)   state_d = StDone;
      else                         state_d = StPost;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        // Full buffer: drop the oldest entry to make room.
        if (count_q == DepthC) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          ovf_d    = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      unique case (state_q)
        StArmed: begin
          cyc_d = cyc_q + 1'b1;
          if (hit) begin
            rem_d   = post_clamped;
            state_d = (post_count == '0) ? StDone : StPost;
          end
        end
        StPost: begin
          cyc_d = cyc_q + 1'b1;
          if (wr_en) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == CW'(1)) state_d = StDone;
          end
        end
        StDone: begin
          if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
            if (count_q == CW'(1)) state_d = StIdle;
          end
        end
        default: ;
      endcase
    end
  end

  // State, pointer and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rem_q    <= '0;
      ovf_q    <= 1'b0;
      cyc_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      ovf_q    <= ovf_d;
      cyc_q    <= cyc_d;
    end
  end

  dbg_trace_ram #(
    .Depth (DEPTH),
    .Width (EW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i ({cyc_q, kind, dbg_pc, data}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  // Head entry is masked to zero when nothing is valid so outputs reset to 0.
  assign rd_data  = rd_valid ? rdata[DATA_W-1:0]               : '0;
  assign rd_pc    = rd_valid ? rdata[2*DATA_W-1:DATA_W]        : '0;
  assign rd_kind  = rd_valid ? rdata[2*DATA_W+1:2*DATA_W]      : '0;
  assign rd_cycle = rd_valid ? rdata[EW-1:2*DATA_W+2]          : '0;

  assign busy     = (state_q == StArmed) || (state_q == StPost);
  assign done     = (state_q == StDone);
  assign overflow = ovf_q;
  assign count    = count_q;

endmodule

// File: tb/tb_dbg_trace_buffer.sv
// Directed self-checking bench for dbg_trace_buffer at DEPTH=16.
module tb_dbg_trace_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dbg_pc, dbg_instr, dbg_alu, dbg_wb, dbg_mem_addr;
  logic        dbg_memread, dbg_memwrite, dbg_wb_we;
  logic        arm;
  logic [1:0]  mode;
  logic        trig_en;
  logic [31:0] trig_pc;
  logic [4:0]  post_count;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_pc, rd_data;
  logic [15:0] rd_cycle;
  logic [1:0]  rd_kind;
  logic        busy, done, overflow;
  logic [4:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  dbg_trace_buffer #(
    .DATA_W (32),
    .DEPTH  (16),
    .CYC_W  (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dbg_pc       (dbg_pc),
    .dbg_instr    (dbg_instr),
    .dbg_alu      (dbg_alu),
    .dbg_wb       (dbg_wb),
    .dbg_mem_addr (dbg_mem_addr),
    .dbg_memread  (dbg_memread),
    .dbg_memwrite (dbg_memwrite),
    .dbg_wb_we    (dbg_wb_we),
    .arm          (arm),
    .mode         (mode),
    .trig_en      (trig_en),
    .trig_pc      (trig_pc),
    .post_count   (post_count),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_pc        (rd_pc),
    .rd_data      (rd_data),
    .rd_cycle     (rd_cycle),
    .rd_kind      (rd_kind),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    dbg_pc = '0; dbg_instr = '0; dbg_alu = '0; dbg_wb = '0; dbg_mem_addr = '0;
    dbg_memread = 1'b0; dbg_memwrite = 1'b0; dbg_wb_we = 1'b0;
  endtask

  task automatic pulse_arm(input logic [1:0] m, input logic te, input logic [31:0] tpc,
                           input logic [4:0] pcnt);
    mode = m; trig_en = te; trig_pc = tpc; post_count = pcnt;
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, overflow, rd_valid, count, rd_kind, rd_cycle, rd_pc, rd_data} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b ovf=%b valid=%b count=%0d want all 0",
               busy, done, overflow, rd_valid, count);
    end
  endtask

  task automatic test_every_cycle();
    idle_bus();
    pulse_arm(2'd0, 1'b0, 32'h0, 5'd8);
    for (int i = 0; i < 8; i++) begin
      dbg_pc  = 32'h100 + 32'(4 * i);
      dbg_alu = 32'hA000 + 32'(i);
      step();
      if (i == 6) begin
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          n_err++;
          $display("FAIL every_busy7: got busy=%b done=%b want busy=1 done=0", busy, done);
        end
      end
    end
    n_cmp++;
    if (done !== 1'b1 || count !== 5'd8 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL every_done8: got done=%b count=%0d ovf=%b want 1 8 0", done, count, overflow);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_cycle !== 16'(i) || rd_kind !== 2'd0 ||
          rd_data !== 32'hA000 + 32'(i) || rd_pc !== 32'h100 + 32'(4 * i)) begin
        n_err++;
        $display("FAIL every_drain%0d: got v=%b cyc=%0d kind=%0d pc=%h data=%h want 1 %0d 0 %h %h",
                 i, rd_valid, rd_cycle, rd_kind, rd_pc, rd_data, i, 32'h100 + 32'(4 * i),
                 32'hA000 + 32'(i));
      end
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
    end
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || rd_valid !== 1'b0 || count !== 5'd0) begin
      n_err++;
      $display("FAIL every_idle: got done=%b busy=%b valid=%b count=%0d want 0 0 0 0",
               done, busy, rd_valid, count);
    end
  endtask

  task automatic test_trigger_wb();
    logic [31:0] pcs [9];
    logic        wes [9];
    int          idx [6];
    pcs = '{32'h30, 32'h34, 32'h38, 32'h40, 32'h44, 32'h48, 32'h4c, 32'h50, 32'h54};
    wes = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    idx = '{0, 2, 4, 6, 7, 8};
    idle_bus();
    dbg_alu = 32'hDEAD;
    pulse_arm(2'd1, 1'b1, 32'h40, 5'd4);
    for (int i = 0; i < 9; i++) begin
      dbg_pc    = pcs[i];
      dbg_wb_we = wes[i];
      dbg_wb    = 32'hB000 + 32'(i);
      step();
    end
    idle_bus();
    n_cmp++;
    if (done !== 1'b1 || count !== 5'd6) begin
      n_err++;
      $display("FAIL trig_done: got done=%b count=%0d want 1 6", done, count);
    end
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (rd_cycle !== 16'(idx[k]) || rd_pc !== pcs[idx[k]] || rd_kind !== 2'd1 ||
          rd_data !== 32'hB000 + 32'(idx[k])) begin
        n_err++;
        $display("FAIL trig_entry%0d: got cyc=%0d pc=%h kind=%0d data=%h want %0d %h 1 %h",
                 k, rd_cycle, rd_pc, rd_kind, rd_data, idx[k], pcs[idx[k]],
                 32'hB000 + 32'(idx[k]));
      end
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
    end
  endtask

  task automatic test_overflow();
    idle_bus();
    pulse_arm(2'd1, 1'b1, 32'h1000, 5'd0);
    dbg_wb_we = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dbg_pc = (i == 19) ? 32'h1000 : 32'(4 * i);
      dbg_wb = 32'(i);
      step();
    end
    idle_bus();
    n_cmp++;
    if (done !== 1'b1 || overflow !== 1'b1 || count !== 5'd16) begin
      n_err++;
      $display("FAIL ovf_state: got done=%b ovf=%b count=%0d want 1 1 16", done, overflow, count);
    end
    n_cmp++;
    if (rd_cycle !== 16'd4 || rd_pc !== 32'h10 || rd_data !== 32'd4) begin
      n_err++;
      $display("FAIL ovf_oldest: got cyc=%0d pc=%h data=%h want 4 10 4", rd_cycle, rd_pc, rd_data);
    end
  endtask

  task automatic test_kind_priority();
    logic [1:0]  exp_kind [4];
    logic [31:0] exp_data [4];
    exp_kind = '{2'd3, 2'd2, 2'd1, 2'd0};
    exp_data = '{32'hC0, 32'hC1, 32'hD2, 32'hE3};
    idle_bus();
    pulse_arm(2'd0, 1'b0, 32'h0, 5'd4);
    for (int i = 0; i < 4; i++) begin
      dbg_memwrite = (i == 0);
      dbg_memread  = (i == 1);
      dbg_wb_we    = (i <= 2);
      dbg_mem_addr = 32'hC0 + 32'(i);
      dbg_wb       = 32'hD0 + 32'(i);
      dbg_alu      = 32'hE0 + 32'(i);
      step();
    end
    idle_bus();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rd_kind !== exp_kind[i] || rd_data !== exp_data[i]) begin
        n_err++;
        $display("FAIL kind%0d: got kind=%0d data=%h want %0d %h",
                 i, rd_kind, rd_data, exp_kind[i], exp_data[i]);
      end
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
    end
  endtask

  task automatic test_clamp_and_stall();
    idle_bus();
    pulse_arm(2'd0, 1'b0, 32'h0, 5'd20);
    for (int i = 0; i < 16; i++) begin
      dbg_alu = 32'h5000 + 32'(i);
      step();
      if (i == 14) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL clamp_busy15: got busy=%b want 1", busy);
        end
      end
    end
    n_cmp++;
    if (done !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL clamp_done: got done=%b count=%0d ovf=%b want 1 16 0", done, count, overflow);
    end
    // rd_ready 1, 0, 0, 1: exactly two pops, head frozen during the stall.
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    step();
    n_cmp++;
    if (count !== 5'd15 || rd_cycle !== 16'd1 || rd_data !== 32'h5001 || rd_kind !== 2'd0) begin
      n_err++;
      $display("FAIL stall_hold: got count=%0d cyc=%0d data=%h kind=%0d want 15 1 5001 0",
               count, rd_cycle, rd_data, rd_kind);
    end
    step();
    n_cmp++;
    if (count !== 5'd15 || rd_cycle !== 16'd1 || rd_data !== 32'h5001) begin
      n_err++;
      $display("FAIL stall_hold2: got count=%0d cyc=%0d data=%h want 15 1 5001",
               count, rd_cycle, rd_data);
    end
    rd_ready = 1'b1;
    step();
    n_cmp++;
    if (count !== 5'd14 || rd_cycle !== 16'd2) begin
      n_err++;
      $display("FAIL stall_pop2: got count=%0d cyc=%0d want 14 2", count, rd_cycle);
    end
    for (int i = 0; i < 13; i++) step();
    n_cmp++;
    if (count !== 5'd1 || done !== 1'b1 || rd_cycle !== 16'd15) begin
      n_err++;
      $display("FAIL stall_last: got count=%0d done=%b cyc=%0d want 1 1 15", count, done, rd_cycle);
    end
    step();
    rd_ready = 1'b0;
    n_cmp++;
    if (count !== 5'd0 || done !== 1'b0 || busy !== 1'b0 || rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_idle: got count=%0d done=%b busy=%b valid=%b want 0 0 0 0",
               count, done, busy, rd_valid);
    end
  endtask

  task automatic test_reset_and_arm();
    idle_bus();
    pulse_arm(2'd0, 1'b0, 32'h0, 5'd8);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (count !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_post: got count=%0d busy=%b done=%b want 0 0 0", count, busy, done);
    end
    pulse_arm(2'd0, 1'b0, 32'h0, 5'd2);
    step(); step();
    // Arm together with a pop: the pop is discarded and capture restarts.
    trig_en = 1'b1; trig_pc = 32'h0000_0200; dbg_pc = 32'h0000_0200;
    arm = 1'b1; rd_ready = 1'b1;
    step();
    arm = 1'b0; rd_ready = 1'b0;
    n_cmp++;
    if (count !== 5'd0 || busy !== 1'b1 || rd_valid !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL arm_pop: got count=%0d busy=%b valid=%b done=%b want 0 1 0 0",
               count, busy, rd_valid, done);
    end
    // Arm while the PC matches the trigger: still armed, nothing captured.
    post_count = 5'd0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || count !== 5'd0) begin
      n_err++;
      $display("FAIL arm_trig: got busy=%b done=%b count=%0d want 1 0 0", busy, done, count);
    end
    step();
    n_cmp++;
    if (done !== 1'b1 || count !== 5'd1 || rd_pc !== 32'h200 || rd_cycle !== 16'd0) begin
      n_err++;
      $display("FAIL trig_entry: got done=%b count=%0d pc=%h cyc=%0d want 1 1 200 0",
               done, count, rd_pc, rd_cycle);
    end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; mode = 2'd0; trig_en = 1'b0; trig_pc = '0; post_count = '0;
    rd_ready = 1'b0;
    idle_bus();
    test_reset();
    test_every_cycle();
    test_trigger_wb();
    test_overflow();
    test_kind_priority();
    test_clamp_and_stall();
    test_reset_and_arm();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dbg_trace_buffer.md
# dbg_trace_buffer

Synthesizable on-chip trace capture for the pipelined MIPS core's debug bus. Sits beside `cpu_top` and samples the `dbg_*` signals each cycle. Stores qualifying events in a parametrised circular buffer around a PC trigger, with selectable pre- and post-trigger windows. Captured entries drain through a valid/ready read port, so post-silicon and GLS runs can recover execution history without a waveform dump.

## Interface
Parameters:
- `DATA_W`, 32: width of PC/instr/data fields.
- `DEPTH`, 16: entries in trace buffer; power of two, ≥2.
- `CYC_W`, 16: cycle-stamp width.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high.
- `dbg_pc`, `dbg_instr`, `dbg_alu`, `dbg_wb`, `dbg_mem_addr` in DATA_W: core debug bus.
- `dbg_memread`, `dbg_memwrite`, `dbg_wb_we` in 1: core debug strobes.
- `arm` in 1: one-cycle pulse; clears buffer and starts a capture.
- `mode` in 2: qualifier. 0 = every cycle; 1 = `dbg_wb_we`; 2 = memread|memwrite; 3 = wb|mem.
- `trig_en` in 1: 0 = trigger immediately at arm.
- `trig_pc` in DATA_W: trigger address.
- `post_count` in $clog2(DEPTH)+1: entries to capture after trigger.
- `rd_valid` out 1, `rd_ready` in 1: readout handshake.
- `rd_pc`, `rd_data` out DATA_W; `rd_cycle` out CYC_W; `rd_kind` out 2: head entry.
- `busy` out 1: state is ARMED or POST.
- `done` out 1: state is DONE.
- `overflow` out 1: pre-trigger data was overwritten.
- `count` out $clog2(DEPTH)+1: valid entries held.

## Operation
- States: IDLE, ARMED, POST, DONE.
- Entry format is {cycle, kind, pc, data}.
  - `kind` priority: 3 = memwrite, 2 = memread, 1 = wb_we, 0 = none.
  - `data`: `dbg_mem_addr` for kind 2/3, `dbg_wb` for kind 1, `dbg_alu` for kind 0.
- A cycle qualifies per `mode`.
- `arm` (any state except IDLE-with-rst) clears wr_ptr, rd_ptr, count, overflow and cycle counter.
  - Next state is ARMED if `trig_en`=1; otherwise POST with remaining=`post_count`.
  - If `trig_en`=0 and `post_count`=0, next state is DONE.
- ARMED:
  - Each qualifying cycle writes one entry at wr_ptr.
  - When full, the oldest entry is overwritten (rd_ptr advances) and `overflow`←1.
  - Trigger is `dbg_pc`==`trig_pc`. The trigger-cycle entry is written if qualifying.
  - On trigger, next state is POST with remaining=`post_count`, or DONE if `post_count`=0.
- POST:
  - Qualifying cycles write entries; remaining decrements per write.
  - After the write that takes remaining to 0, next state is DONE.
  - If the buffer is full, the oldest entry is overwritten as in ARMED.
  - `post_count` > DEPTH is clamped to DEPTH.
- DONE:
  - `rd_valid`=(count≠0); `rd_*` show entry at rd_ptr.
  - On rd_valid&rd_ready: rd_ptr++, count--.
  - When the pop empties the buffer, next state is IDLE.
- `rd_valid` is 0 in all states other than DONE.
- Cycle counter increments every cycle in ARMED/POST and wraps modulo 2^CYC_W; it holds otherwise.
- Pointers wrap modulo DEPTH.

## Timing
- Reset value of every output is 0. State IDLE, pointers, counters and `overflow` are 0.
- Debug bus sampled at posedge N appears in the buffer at N+1 and is readable from the first DONE cycle.
- `rd_*` are a combinational read of the registered array at rd_ptr. Zero-latency pop: the next entry is presented the cycle after the handshake.
- `busy`, `done`, `count` and `overflow` are registered and reflect state after each edge.
- Simultaneous events:
  - `arm` with a read handshake: `arm` wins, the pop is discarded.
  - `arm` with a trigger match: `arm` wins.
  - `rst` dominates everything. Reset mid-capture discards the buffer and leaves the state IDLE.
- `rd_kind`/`rd_data` are stable while rd_valid=1 and rd_ready=0.

## Structure
- Package `dbg_trace_pkg` holds:
  - the state enum;
  - kind encodings;
  - `mode` constants;
  - the entry struct typedef, parametrised by function or localparam widths.
- Sub-module `dbg_trace_ram`: DEPTH×entry flop array, one write port, one asynchronous read port. Used for the buffer so it can later be swapped for a sky130 macro.
- Control FSM, pointers and cycle counter live in the top.

## Test plan
- arm, mode=0, trig_en=0, post_count=8, DEPTH=16 → done after 8 cycles; drain yields 8 entries with rd_cycle 0..7 and overflow=0.
- mode=1, trig_pc=0x40, with wb_we on cycles before and after PC 0x40, post_count=4 → last 4 entries are the post-trigger writebacks; rd_kind=1 and rd_data=dbg_wb.
- 20 qualifying cycles in ARMED before trigger, DEPTH=16, post_count=0 → overflow=1, count=16, oldest rd_cycle=4.
- memwrite and wb_we in the same cycle → rd_kind=3, rd_data=dbg_mem_addr.
- DONE with rd_ready toggled 1,0,1 → exactly 2 pops, stable rd_* during the stall; state returns to IDLE when count=0.
- rst asserted in POST, then arm pulsed with a read handshake → count=0, busy=1, rd_valid=0.
